// File: rtl/onchip_mem_arb_pkg.sv
// onchip_mem_arb_pkg: shared types and default parameters
// for the dual-master on-chip RAM arbiter.
package onchip_mem_arb_pkg;

  localparam int ADDR_W_DEF   = 15;
  localparam int DATA_W_DEF   = 32;
  localparam int DEPTH_DEF    = 25000;
  localparam int MAX_HOLD_DEF = 8;
  localparam int HOLD_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef logic mst_id_t;

  function automatic arb_state_e own_state(
    input mst_id_t id
  );
    return id ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// onchip_mem_arbiter_if: both master ports plus the RAM port.
// slave = arbiter view, master = masters and RAM view.
interface onchip_mem_arbiter_if
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] m0_address;
  logic [BE_W-1:0]   m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  m0_address, m0_byteenable,
    input  m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata,
    output m0_readdatavalid,
    input  m1_address, m1_byteenable,
    input  m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata,
    output m1_readdatavalid,
    output mem_address, mem_byteenable,
    output mem_chipselect, mem_write,
    output mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output m0_address, m0_byteenable,
    output m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata,
    input  m0_readdatavalid,
    output m1_address, m1_byteenable,
    output m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata,
    input  m1_readdatavalid,
    input  mem_address, mem_byteenable,
    input  mem_chipselect, mem_write,
    input  mem_writedata, mem_clken,
    output mem_readdata
  );

endinterface

// File: rtl/onchip_mem_arb_rdtrack.sv
// onchip_mem_arb_rdtrack: one-stage read-return tracker that
// steers mem_readdata back to the master that issued the read.
module onchip_mem_arb_rdtrack
  import onchip_mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_vld,
  input  mst_id_t           cap_id,
  input  logic              cap_oor,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  logic    vld_q;
  mst_id_t id_q;
  logic    oor_q;
  logic    live;
  logic [DATA_W-1:0] ret_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      id_q  <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      vld_q <= cap_vld;
      id_q  <= cap_id;
      oor_q <= cap_oor;
    end
  end

  // Out-of-range reads never touched the RAM, so answer zero.
  assign live     = vld_q & ~reset;
  assign ret_data = oor_q ? '0 : mem_readdata;

  assign rvalid0 = live & ~id_q;
  assign rvalid1 = live & id_q;
  assign rdata0  = rvalid0 ? ret_data : '0;
  assign rdata1  = rvalid1 ? ret_data : '0;

endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: two-master arbiter in front of one RAM port.
// Define ONCHIP_MEM_ARB_RR_EN for round-robin IDLE tie-break.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic clk,
  input logic reset,
  onchip_mem_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [HOLD_W-1:0] HOLD_LIM =
    HOLD_W'(MAX_HOLD);

  arb_state_e state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic req0, req1, hold_ok;
  logic gnt_vld;
  mst_id_t gnt_id, tie_id;

  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic sel_rd, sel_wr;
  logic in_range, mem_hit;

  assign req0    = bus.m0_read | bus.m0_write;
  assign req1    = bus.m1_read | bus.m1_write;
  assign hold_ok = hold_q < HOLD_LIM;

`ifdef ONCHIP_MEM_ARB_RR_EN
  // Pointer holds the last granted master; reset value 1 favours master 0.
  mst_id_t last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (gnt_vld) begin
      last_q <= gnt_id;
    end
  end

  assign tie_id = ~last_q;
`else
  assign tie_id = 1'b0;
`endif

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (!reset && (req0 || req1)) begin
      gnt_vld = 1'b1;
      if (req0 && req1) begin
        unique case (state_q)
          OWN0:    gnt_id = ~hold_ok;
          OWN1:    gnt_id = hold_ok;
          default: gnt_id = tie_id;
        endcase
      end else begin
        gnt_id = req1;
      end
    end
  end

  always_comb begin
    state_d = IDLE;
    hold_d  = '0;
    if (gnt_vld) begin
      state_d = own_state(gnt_id);
      if (state_q != state_d) begin
        hold_d = HOLD_W'(1);
      end else if (hold_ok) begin
        hold_d = hold_q + HOLD_W'(1);
      end else begin
        hold_d = hold_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_be    = '0;
    sel_wdata = '0;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    unique case (1'b1)
      (gnt_vld & ~gnt_id): begin
        sel_addr  = bus.m0_address;
        sel_be    = bus.m0_byteenable;
        sel_wdata = bus.m0_writedata;
        sel_rd    = bus.m0_read;
        sel_wr    = bus.m0_write;
      end
      (gnt_vld & gnt_id): begin
        sel_addr  = bus.m1_address;
        sel_be    = bus.m1_byteenable;
        sel_wdata = bus.m1_writedata;
        sel_rd    = bus.m1_read;
        sel_wr    = bus.m1_write;
      end
      default: ;
    endcase
  end

  assign in_range = 32'(sel_addr) < 32'(DEPTH);
  assign mem_hit  = gnt_vld & in_range;

  assign bus.m0_waitrequest = ~(gnt_vld & ~gnt_id);
  assign bus.m1_waitrequest = ~(gnt_vld & gnt_id);

  assign bus.mem_address    = sel_addr;
  assign bus.mem_byteenable = sel_be;
  assign bus.mem_writedata  = sel_wdata;
  assign bus.mem_chipselect = mem_hit;
  assign bus.mem_write      = mem_hit & sel_wr;
  assign bus.mem_clken      = ~reset;

  // Read+write together is treated as a write: no data returned.
  onchip_mem_arb_rdtrack #(
    .DATA_W(DATA_W)
  ) u_rdtrack (
    .clk          (clk),
    .reset        (reset),
    .cap_vld      (gnt_vld & sel_rd & ~sel_wr),
    .cap_id       (gnt_id),
    .cap_oor      (~in_range),
    .mem_readdata (bus.mem_readdata),
    .rvalid0      (bus.m0_readdatavalid),
    .rvalid1      (bus.m1_readdatavalid),
    .rdata0       (bus.m0_readdata),
    .rdata1       (bus.m1_readdata)
  );

endmodule
